multdiv_ctrl: RTL and testbench

Sequencing controller for the multiply/divide unit and the P/W pipeline latch. It decodes `mul`/`div` in the execute stage and issues a one-cycle start pulse to the multdiv unit. It holds the pipeline stalled until the result is ready, then strobes the P/W latch enable together with an rstatus exception indication. It sits beside the X stage, between the X/M latch control and the P/W latch.

---
 rtl/multdiv_ctrl.sv | 136 +++++++++++++
 tb/tb_multdiv_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl
//   Sequencing controller for the multiply/divide unit and the P/W latch.
//   It decodes mul/div in the X stage and issues a one-cycle start pulse.
//   It stalls the pipeline until the multdiv result is ready. On release it
//   strobes the P/W latch enable together with the rstatus exception code.
//
//   Optional feature macro: MULTDIV_TIMEOUT_EN
//     defined   : a saturating BUSY-cycle counter forces completion after
//                 TIMEOUT cycles, with pw_exc=1.
//     undefined : no counter; BUSY waits indefinitely for md_resultRDY.
//
// Parameters
//   TIMEOUT       max BUSY cycles before forced completion (timeout build only)
// Ports
//   clk           pipeline clock, rising edge
//   reset         asynchronous, active-low reset
//   x_IR[31:0]    instruction currently in X
//   md_resultRDY  multdiv result valid
//   md_exception  multdiv overflow / divide-by-zero, valid with md_resultRDY
//   ctrl_MULT     one-cycle multiply start pulse
//   ctrl_DIV      one-cycle divide start pulse
//   stall         freeze PC, F/D, D/X; bubble into X/M
//   pw_we         P/W latch input enable, one cycle
//   pw_exc        exception flag accompanying pw_we
//   pw_rstatus    4 (mul) or 5 (div) when pw_exc, else 0
//   busy          high in BUSY state
module multdiv_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] x_IR,
    input  logic        md_resultRDY,
    input  logic        md_exception,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall,
    output logic        pw_we,
    output logic        pw_exc,
    output logic [31:0] pw_rstatus,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state, state_next;
    logic   op_is_div;
    logic   is_mul, is_div, is_md;
    logic   timeout;
    logic   unused_ir;

    assign is_mul    = (x_IR[31:27] == 5'b00000) && (x_IR[6:2] == 5'b00110);
    assign is_div    = (x_IR[31:27] == 5'b00000) && (x_IR[6:2] == 5'b00111);
    assign is_md     = is_mul || is_div;
    assign unused_ir = ^{x_IR[26:7], x_IR[1:0]};

`ifdef MULTDIV_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Counter holds at 0 in IDLE so it is clear on entry to BUSY, then
    // counts BUSY cycles and saturates at TIMEOUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else if (cnt != CW'(TIMEOUT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt == TIMEOUT-1 during the TIMEOUT-th BUSY cycle.
    assign timeout = (state == BUSY) && (cnt == CW'(TIMEOUT - 1));
`else
    // No forced completion in this build.
    assign timeout = (TIMEOUT == 0) && 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op_is_div <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && is_md) begin
                op_is_div <= is_div;
            end
        end
    end

    // Outputs are gated by reset so that asserting reset mid-operation
    // zeroes them at once, even with a mul/div sitting in X.
    always_comb begin
        state_next = state;
        ctrl_MULT  = 1'b0;
        ctrl_DIV   = 1'b0;
        stall      = 1'b0;
        pw_we      = 1'b0;
        pw_exc     = 1'b0;
        pw_rstatus = '0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                if (is_md && reset) begin
                    ctrl_MULT  = is_mul;
                    ctrl_DIV   = is_div;
                    stall      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (reset) begin
                    busy  = 1'b1;
                    stall = 1'b1;
                    if (md_resultRDY || timeout) begin
                        // A real result wins over a coincident timeout.
                        stall      = 1'b0;
                        pw_we      = 1'b1;
                        pw_exc     = md_resultRDY ? md_exception : 1'b1;
                        state_next = IDLE;
                        if (pw_exc) begin
                            pw_rstatus = op_is_div ? 32'd5 : 32'd4;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
module tb_multdiv_ctrl;

    localparam int unsigned TIMEOUT = 64;
    localparam int EV_MULT = 1;
    localparam int EV_DIV  = 2;
    localparam int EV_PW   = 3;

    logic        clk;
    logic        reset;
    logic [31:0] x_IR;
    logic        md_resultRDY;
    logic        md_exception;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic        stall;
    logic        pw_we;
    logic        pw_exc;
    logic [31:0] pw_rstatus;
    logic        busy;

    multdiv_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .x_IR         (x_IR),
        .md_resultRDY (md_resultRDY),
        .md_exception (md_exception),
        .ctrl_MULT    (ctrl_MULT),
        .ctrl_DIV     (ctrl_DIV),
        .stall        (stall),
        .pw_we        (pw_we),
        .pw_exc       (pw_exc),
        .pw_rstatus   (pw_rstatus),
        .busy         (busy)
    );

    typedef struct {
        int kind;
        int cyc;
        bit exc;
        int rstatus;
        int stall_n;
        int busy_n;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stall_run = 0;
    int   busy_run = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] make_md(input bit dv);
        logic [31:0] ir;
        ir       = $urandom;
        ir[31:27] = 5'b00000;
        ir[6:2]   = dv ? 5'b00111 : 5'b00110;
        return ir;
    endfunction

    // Random non-mul/div instruction; sometimes a near miss on the decode.
    function automatic logic [31:0] make_other();
        logic [31:0] ir;
        ir = $urandom;
        if ($urandom_range(0, 2) == 0) begin
            ir[31:27] = 5'b00000;
            ir[6:2]   = ($urandom_range(0, 1) == 0) ? 5'b00101 : 5'b01000;
        end
        if (ir[31:27] == 5'b00000 && (ir[6:2] == 5'b00110 || ir[6:2] == 5'b00111))
            ir[27] = 1'b1;
        return ir;
    endfunction

    // Issue a mul/div in the current cycle; the result arrives in BUSY cycle n.
    task automatic run_md(input bit dv, input int n, input bit exc);
        int  c;
        int  rel;
        bit  texc;
        exp_t e;
        x_IR         = make_md(dv);
        md_resultRDY = $urandom_range(0, 1);  // ignored in issue cycle
        md_exception = $urandom_range(0, 1);
        c    = cyc;
        rel  = n;
        texc = exc;
`ifdef MULTDIV_TIMEOUT_EN
        if (n > TIMEOUT) begin
            rel  = TIMEOUT;
            texc = 1'b1;
        end
`endif
        e = '{dv ? EV_DIV : EV_MULT, c, 1'b0, 0, 0, 0};
        expq.push_back(e);
        e = '{EV_PW, c + rel, texc, texc ? (dv ? 5 : 4) : 0, rel, rel};
        expq.push_back(e);
        for (int k = 1; k <= rel; k++) begin
            next_cycle();
            md_resultRDY = (k == n);
            md_exception = (k == n) ? exc : 1'($urandom_range(0, 1));
        end
        next_cycle();
    endtask

    task automatic run_other(input int n);
        for (int k = 0; k < n; k++) begin
            x_IR         = make_other();
            md_resultRDY = $urandom_range(0, 1);  // stale, must be ignored
            md_exception = $urandom_range(0, 1);
            next_cycle();
        end
    endtask

    // Issue, then pull reset low in BUSY cycle abort_at; reissue afterwards.
    task automatic run_reset_abort(input bit dv, input int abort_at, input int n, input bit exc);
        exp_t e;
        x_IR         = make_md(dv);
        md_resultRDY = 1'b0;
        e = '{dv ? EV_DIV : EV_MULT, cyc, 1'b0, 0, 0, 0};
        expq.push_back(e);
        for (int k = 1; k <= abort_at; k++) begin
            next_cycle();
            md_resultRDY = 1'b0;
        end
        #1 reset = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        md_resultRDY = 1'b0;
        run_md(dv, n, exc);  // same instruction still in X
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        int   kind;
        if (!reset) begin
            checks++;
            if ({ctrl_MULT, ctrl_DIV, stall, pw_we, pw_exc, busy} != 6'b0 || pw_rstatus != 32'd0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got mult=%b div=%b stall=%b we=%b exc=%b rst=%0d busy=%b want all 0",
                         cyc, ctrl_MULT, ctrl_DIV, stall, pw_we, pw_exc, pw_rstatus, busy);
            end
            stall_run = 0;
            busy_run  = 0;
        end else begin
            if (stall) stall_run++;
            if (busy)  busy_run++;
            if (!pw_we && (pw_exc || pw_rstatus != 32'd0)) begin
                checks++;
                errors++;
                $display("FAIL idle_pw cyc=%0d got exc=%b rst=%0d want 0 without pw_we", cyc, pw_exc, pw_rstatus);
            end
            if (ctrl_MULT || ctrl_DIV || pw_we) begin
                kind = 0;
                if (ctrl_MULT && !ctrl_DIV && !pw_we) kind = EV_MULT;
                if (!ctrl_MULT && ctrl_DIV && !pw_we) kind = EV_DIV;
                if (!ctrl_MULT && !ctrl_DIV && pw_we) kind = EV_PW;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d got kind=%0d want none", cyc, kind);
                end else begin
                    e = expq.pop_front();
                    if (kind != e.kind || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL event got kind=%0d cyc=%0d want kind=%0d cyc=%0d", kind, cyc, e.kind, e.cyc);
                    end
                    if (e.kind == EV_PW) begin
                        checks++;
                        if (pw_exc != e.exc || pw_rstatus != e.rstatus || stall) begin
                            errors++;
                            $display("FAIL pw_fields cyc=%0d got exc=%b rst=%0d stall=%b want exc=%b rst=%0d stall=0",
                                     cyc, pw_exc, pw_rstatus, stall, e.exc, e.rstatus);
                        end
                        checks++;
                        if (stall_run != e.stall_n || busy_run != e.busy_n) begin
                            errors++;
                            $display("FAIL stall_len cyc=%0d got stall=%0d busy=%0d want stall=%0d busy=%0d",
                                     cyc, stall_run, busy_run, e.stall_n, e.busy_n);
                        end
                        stall_run = 0;
                        busy_run  = 0;
                    end else begin
                        checks++;
                        if (!stall || busy) begin
                            errors++;
                            $display("FAIL issue_stall cyc=%0d got stall=%b busy=%b want stall=1 busy=0", cyc, stall, busy);
                        end
                    end
                end
            end
        end
    end

    initial begin
        fork
            begin
                #3000000;
                $display("FAIL watchdog cyc=%0d got no end want finish", cyc);
                errors++;
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1);
            end
        join_none

        reset        = 1'b0;
        x_IR         = make_md(1'b0);  // mul in X during reset: no pulse
        md_resultRDY = 1'b1;
        md_exception = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        reset = 1'b1;
        run_other(3);

        run_md(1'b0, 33, 1'b0);        // mul, ready in BUSY cycle 33
        run_other(2);
        run_md(1'b1, 12, 1'b1);        // div with exception -> rstatus 5
        run_other(1);
        run_md(1'b0, 7, 1'b0);         // back-to-back mul then div
        run_md(1'b1, 9, 1'b0);
        run_md(1'b0, 1, 1'b1);         // ready in first BUSY cycle
        run_other(4);                  // stale ready in IDLE
        run_reset_abort(1'b0, 10, 5, 1'b0);
        run_other(1);
        run_md(1'b0, TIMEOUT, 1'b0);   // ready coincides with timeout limit
        run_md(1'b1, TIMEOUT - 1, 1'b1);
        run_md(1'b0, 210, 1'b0);       // long wait: timeout or >200 stall
        run_other(1);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: run_other($urandom_range(1, 3));
                1: run_md(1'($urandom_range(0, 1)), $urandom_range(TIMEOUT - 2, TIMEOUT + 6),
                          1'($urandom_range(0, 1)));
                2: run_reset_abort(1'($urandom_range(0, 1)), $urandom_range(1, 8),
                                   $urandom_range(1, 20), 1'($urandom_range(0, 1)));
                default: run_md(1'($urandom_range(0, 1)), $urandom_range(1, 40),
                                1'($urandom_range(0, 1)));
            endcase
        end

        run_other(4);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL leftover_events got %0d want 0", expq.size());
        end
        checks++;
        if (stall_run != 0 || busy_run != 0) begin
            errors++;
            $display("FAIL trailing_stall got stall=%0d busy=%0d want 0", stall_run, busy_run);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
